// File: rtl/seg7_scan.sv
// Multiplexed 6-digit 7-segment scanner for an HH.MM.SS display with per-frame digit snapshot.
// Optional leading-zero blanking of the hours-tens digit: define LZ_BLANK_EN.
module seg7_scan #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] h10,
  input  logic [3:0] h1,
  input  logic [2:0] m10,
  input  logic [3:0] m1,
  input  logic [2:0] s10,
  input  logic [3:0] s1,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam logic [15:0] CNT_MAX = 16'(SCAN_DIV - 1);

  typedef enum logic {BLANK, SCAN} state_t;

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  idx_reg, idx_next;
  logic [3:0]  snap_reg [6];
  logic [3:0]  snap_next [6];
  logic [3:0]  live [6];
  logic [5:0]  an_reg, an_next;
  logic [6:0]  seg_reg, seg_next;
  logic        dp_reg, dp_next;
  logic        frame_done_reg, frame_done_next;
  logic [2:0]  nidx;
  logic [3:0]  digit;

  // Digit order matches anode order: slot 0 is seconds units, slot 5 hours tens.
  assign live[0] = s1;
  assign live[1] = {1'b0, s10};
  assign live[2] = m1;
  assign live[3] = {1'b0, m10};
  assign live[4] = h1;
  assign live[5] = {2'b00, h10};

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0:    dec = 7'h3F;
      4'd1:    dec = 7'h06;
      4'd2:    dec = 7'h5B;
      4'd3:    dec = 7'h4F;
      4'd4:    dec = 7'h66;
      4'd5:    dec = 7'h6D;
      4'd6:    dec = 7'h7D;
      4'd7:    dec = 7'h07;
      4'd8:    dec = 7'h7F;
      4'd9:    dec = 7'h6F;
      default: dec = 7'h40;
    endcase
  endfunction

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    snap_next       = snap_reg;
    an_next         = an_reg;
    seg_next        = seg_reg;
    dp_next         = dp_reg;
    frame_done_next = 1'b0;
    nidx            = '0;
    digit           = '0;

    case (state_reg)
      BLANK: begin
        an_next  = '0;
        seg_next = '0;
        dp_next  = 1'b0;
        cnt_next = '0;
        idx_next = '0;
        if (en) begin
          snap_next       = live;
          an_next         = 6'b000001;
          seg_next        = dec(s1);
          frame_done_next = 1'b1;
          state_next      = SCAN;
        end
      end
      SCAN: begin
        if (!en) begin
          state_next = BLANK;
          an_next    = '0;
          seg_next   = '0;
          dp_next    = 1'b0;
          cnt_next   = '0;
          idx_next   = '0;
        end else if (cnt_reg == CNT_MAX) begin
          cnt_next = '0;
          if (idx_reg == 3'd5) begin
            // Frame wrap: fresh snapshot, and slot 0 shows the live seconds digit now.
            nidx            = 3'd0;
            snap_next       = live;
            frame_done_next = 1'b1;
            digit           = s1;
          end else begin
            nidx  = idx_reg + 3'd1;
            digit = snap_reg[nidx];
          end
          idx_next = nidx;
          an_next  = 6'b000001 << nidx;
          seg_next = dec(digit);
          dp_next  = (nidx == 3'd2) || (nidx == 3'd4);
`ifdef LZ_BLANK_EN
          if ((nidx == 3'd5) && (snap_reg[5] == 4'd0)) begin
            an_next  = '0;
            seg_next = '0;
          end
`endif
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: state_next = BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= BLANK;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      an_reg         <= '0;
      seg_reg        <= '0;
      dp_reg         <= 1'b0;
      frame_done_reg <= 1'b0;
      for (int i = 0; i < 6; i++) snap_reg[i] <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      dp_reg         <= dp_next;
      frame_done_reg <= frame_done_next;
      for (int i = 0; i < 6; i++) snap_reg[i] <= snap_next[i];
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign frame_done = frame_done_reg;

endmodule
